// File: rtl/param_updown_counter_pkg.sv
// cnt_pkg: shared direction constants and elaboration helpers for param_updown_counter.
// No ports. Provides clamp_load() for saturating parallel loads and width_ok()
// for the elaboration-time configuration check.
package cnt_pkg;
    localparam logic CNT_DIR_UP = 1'b1;
    localparam logic CNT_DIR_DN = 1'b0;

    function automatic longint unsigned clamp_load(input longint unsigned val, input longint unsigned modulus);
        return (val > modulus - 1) ? modulus - 1 : val;
    endfunction

    function automatic bit width_ok(input int width, input longint unsigned modulus);
        return (width >= 1) && (width <= 32) && (modulus >= 2) && (modulus <= (64'd1 << width));
    endfunction
endpackage

// File: rtl/param_updown_counter_if.sv
// param_updown_counter_if: control and status bundle of param_updown_counter.
// master drives clr/en/up_dn/load/load_val and observes count/wrap/overflow/step;
// slave is the counter side.
interface param_updown_counter_if #(parameter int WIDTH = 8);
    logic             clr;
    logic             en;
    logic             up_dn;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             wrap;
    logic             overflow;
    logic             step;

    modport master (output clr, en, up_dn, load, load_val, input count, wrap, overflow, step);
    modport slave  (input clr, en, up_dn, load, load_val, output count, wrap, overflow, step);
endinterface

// File: rtl/param_updown_counter_prescaler.sv
// cnt_prescaler: divides enabled cycles by PRESCALE and flags the step cycle.
// Ports: clk, rst (async active-low), clr_sync (restart phase), en (advance),
// tick (combinational, high when en and the phase is at PRESCALE-1).
module cnt_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_sync,
    input  logic en,
    output logic tick
);
    if (PRESCALE == 1) begin : g_none
        // No phase state needed: every enabled cycle is a step.
        logic unused_ok;
        assign unused_ok = clk ^ rst ^ clr_sync;
        assign tick = en;
    end else begin : g_div
        localparam int PW = $clog2(PRESCALE);
        localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);
        logic [PW-1:0] cnt;
        assign tick = en && (cnt == LAST);
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) cnt <= '0;
            else if (clr_sync) cnt <= '0;
            else if (en) cnt <= tick ? '0 : cnt + PW'(1);
        end
    end
endmodule

// File: rtl/param_updown_counter.sv
// param_updown_counter: prescaled up/down modulo counter with clear, load, wrap and sticky overflow.
// Ports: clk, rst (async active-low), bus (param_updown_counter_if.slave).
// Build option: define PARAM_CNT_SATURATE_EN to hold at the bounds instead of wrapping.
module param_updown_counter
    import cnt_pkg::*;
#(
    parameter int              WIDTH    = 8,
    parameter longint unsigned MODULUS  = 256,
    parameter int              PRESCALE = 1
) (
    input logic                   clk,
    input logic                   rst,
    param_updown_counter_if.slave bus
);
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    if (!width_ok(WIDTH, MODULUS) || PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_cfg
        $error("param_updown_counter: illegal WIDTH/MODULUS/PRESCALE combination");
    end

    logic             tick, up, at_bound;
    logic [WIDTH-1:0] count_q, count_d, stepped;
    logic             wrap_q, wrap_d, ovf_q, ovf_d, step_q, step_d;

    cnt_prescaler #(.PRESCALE(PRESCALE)) u_pre (
        .clk      (clk),
        .rst      (rst),
        .clr_sync (bus.clr | bus.load),
        .en       (bus.en),
        .tick     (tick)
    );

    // Bounds are compared explicitly so MODULUS == 2**WIDTH never relies on rollover.
    assign up       = bus.up_dn == CNT_DIR_UP;
    assign at_bound = up ? (count_q == MAX_VAL) : (count_q == '0);
    assign stepped  = up ? count_q + WIDTH'(1) : count_q - WIDTH'(1);

    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        wrap_d  = 1'b0;
        step_d  = 1'b0;
        if (bus.clr) begin
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (bus.load) begin
            count_d = WIDTH'(clamp_load(64'(bus.load_val), MODULUS));
        end else if (tick) begin
`ifdef PARAM_CNT_SATURATE_EN
            count_d = at_bound ? count_q : stepped;
            ovf_d   = ovf_q | at_bound;
            step_d  = !at_bound;
`else
            count_d = at_bound ? (up ? '0 : MAX_VAL) : stepped;
            wrap_d  = at_bound;
            ovf_d   = ovf_q | at_bound;
            step_d  = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
            ovf_q   <= 1'b0;
            step_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            ovf_q   <= ovf_d;
            step_q  <= step_d;
        end
    end

    assign bus.count    = count_q;
    assign bus.wrap     = wrap_q;
    assign bus.overflow = ovf_q;
    assign bus.step     = step_q;
endmodule

// File: tb/tb_param_updown_counter.sv
// tb_param_updown_counter: directed table-driven bench for param_updown_counter.
module tb_param_updown_counter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   passed = 0;
    int   total = 0;

    always #5 clk = ~clk;

    param_updown_counter_if #(.WIDTH(3)) ifa ();
    param_updown_counter_if #(.WIDTH(3)) ifb ();
    param_updown_counter_if #(.WIDTH(3)) ifc ();

    param_updown_counter #(.WIDTH(3), .MODULUS(6), .PRESCALE(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    param_updown_counter #(.WIDTH(3), .MODULUS(6), .PRESCALE(3)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
    param_updown_counter #(.WIDTH(3), .MODULUS(8), .PRESCALE(1)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

    // inputs, then expected {count,wrap,ovf,step} for modulo build, then {count,ovf,step} for saturate build
    typedef struct {
        logic       clr, en, up, ld;
        logic [2:0] lv;
        int         cm, wm, om, sm;
        int         cs, os, ss;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s got %0d expected %0d", name, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input int c, input int w, input int o, input int s);
        chk({tag, "_count"}, int'(ifa.count), c);
        chk({tag, "_wrap"}, int'(ifa.wrap), w);
        chk({tag, "_ovf"}, int'(ifa.overflow), o);
        chk({tag, "_step"}, int'(ifa.step), s);
    endtask

    initial begin
        int ec, ew, eo, es;
        vecs = '{
            '{1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1, 0, 0, 1, 1, 0, 1},
            '{1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 2, 0, 0, 1, 2, 0, 1},
            '{1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 3, 0, 0, 1, 3, 0, 1},
            '{1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 4, 0, 0, 1, 4, 0, 1},
            '{1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 5, 0, 0, 1, 5, 0, 1},
            '{1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 0, 1, 1, 1, 5, 1, 0},
            '{1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1, 0, 1, 1, 5, 1, 0},
            '{1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1, 0, 1, 0, 5, 1, 0},
            '{1'b0, 1'b1, 1'b1, 1'b1, 3'd7, 5, 0, 1, 0, 5, 1, 0},
            '{1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 0, 1, 1, 1, 5, 1, 0},
            '{1'b1, 1'b1, 1'b1, 1'b1, 3'd4, 0, 0, 0, 0, 0, 0, 0},
            '{1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 5, 1, 1, 1, 0, 1, 0},
            '{1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 4, 0, 1, 1, 0, 1, 0},
            '{1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3, 0, 1, 1, 0, 1, 0},
            '{1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 4, 0, 1, 1, 1, 1, 1},
            '{1'b0, 1'b0, 1'b1, 1'b1, 3'd2, 2, 0, 1, 0, 2, 1, 0},
            '{1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 0, 0, 0, 0, 0, 0, 0}
        };
        {ifa.clr, ifa.en, ifa.up_dn, ifa.load, ifa.load_val} = '0;
        {ifb.clr, ifb.en, ifb.up_dn, ifb.load, ifb.load_val} = '0;
        {ifc.clr, ifc.en, ifc.up_dn, ifc.load, ifc.load_val} = '0;
        ifb.up_dn = 1'b1;
        ifc.up_dn = 1'b1;
        cyc();
        cyc();
        chk_all("reset", 0, 0, 0, 0);
        chk("reset_b_count", int'(ifb.count), 0);
        chk("reset_c_count", int'(ifc.count), 0);
        rst = 1'b1;

        for (int i = 0; i < 17; i++) begin
            ifa.clr = vecs[i].clr;
            ifa.en = vecs[i].en;
            ifa.up_dn = vecs[i].up;
            ifa.load = vecs[i].ld;
            ifa.load_val = vecs[i].lv;
            cyc();
`ifdef PARAM_CNT_SATURATE_EN
            ec = vecs[i].cs; ew = 0; eo = vecs[i].os; es = vecs[i].ss;
`else
            ec = vecs[i].cm; ew = vecs[i].wm; eo = vecs[i].om; es = vecs[i].sm;
`endif
            chk_all($sformatf("vec%0d", i), ec, ew, eo, es);
        end

        // MODULUS == 2**WIDTH: wrap at all-ones without natural rollover
        ifc.load = 1'b1; ifc.load_val = 3'd6;
        cyc();
        chk("m8_load", int'(ifc.count), 6);
        ifc.load = 1'b0; ifc.en = 1'b1;
        cyc();
        chk("m8_up7", int'(ifc.count), 7);
        cyc();
`ifdef PARAM_CNT_SATURATE_EN
        chk("m8_top", int'(ifc.count), 7);
        chk("m8_top_wrap", int'(ifc.wrap), 0);
`else
        chk("m8_top", int'(ifc.count), 0);
        chk("m8_top_wrap", int'(ifc.wrap), 1);
`endif
        chk("m8_top_ovf", int'(ifc.overflow), 1);
        ifc.up_dn = 1'b0;
        cyc();
`ifdef PARAM_CNT_SATURATE_EN
        chk("m8_down", int'(ifc.count), 6);
        chk("m8_down_wrap", int'(ifc.wrap), 0);
`else
        chk("m8_down", int'(ifc.count), 7);
        chk("m8_down_wrap", int'(ifc.wrap), 1);
`endif
        ifc.en = 1'b0;

        // PRESCALE = 3: one step every third enabled cycle
        ifb.en = 1'b1;
        for (int i = 0; i < 9; i++) begin
            cyc();
            chk($sformatf("ps_cyc%0d_count", i), int'(ifb.count), (i + 1) / 3);
            chk($sformatf("ps_cyc%0d_step", i), int'(ifb.step), int'((i % 3) == 2));
        end
        cyc();
        chk("ps_mid_count", int'(ifb.count), 3);
        ifb.en = 1'b0;
        cyc();
        cyc();
        chk("ps_hold_count", int'(ifb.count), 3);
        chk("ps_hold_step", int'(ifb.step), 0);
        ifb.en = 1'b1;
        cyc();
        chk("ps_resume_count", int'(ifb.count), 3);
        cyc();
        chk("ps_resume_step_count", int'(ifb.count), 4);
        chk("ps_resume_step", int'(ifb.step), 1);
        ifb.en = 1'b0;

        // asynchronous reset mid-count
        ifa.clr = 1'b0; ifa.load = 1'b0; ifa.up_dn = 1'b1; ifa.en = 1'b1;
        for (int i = 0; i < 5; i++) cyc();
        chk("pre_rst_count", int'(ifa.count), 5);
        #2;
        rst = 1'b0;
        #1;
        chk_all("async_rst", 0, 0, 0, 0);
        cyc();
        chk("rst_held_count", int'(ifa.count), 0);
        rst = 1'b1;
        cyc();
        chk("rst_release_count", int'(ifa.count), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/param_updown_counter.md
Name: param_updown_counter

Overview:
- Parametrised up/down modulo counter with a cycle prescaler, synchronous clear and parallel load.
- Reports wrap events and keeps a sticky overflow flag.
- Replaces the fixed 3-bit ripple up-counter with a fully synchronous, single-clock design.
- Used as a generic event, timebase and divider counter across the design.

Parameters:
- WIDTH, 8, counter width in bits (1..32).
- MODULUS, 256, count range is 0..MODULUS-1. Constraint: 2 <= MODULUS <= 2**WIDTH.
- PRESCALE, 1, number of enabled clk cycles per count step (1..65535). A value of 1 means a step on every enabled cycle.

Ports:
- clk  input  1  sole clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- clr  input  1  synchronous clear of count, prescaler and overflow.
- en  input  1  count enable; qualifies prescaler advance.
- up_dn  input  1  1 = count up, 0 = count down; sampled each cycle.
- load  input  1  synchronous parallel load.
- load_val  input  WIDTH  value loaded when load = 1.
- count  output  WIDTH  current count, registered.
- wrap  output  1  one-cycle registered pulse on modulo wrap.
- overflow  output  1  sticky, set on any wrap, cleared by clr or rst.
- step  output  1  registered pulse, high the cycle after count changed due to counting.

Behaviour:
- Reset: while rst = 0, all outputs (count, wrap, overflow, step) and the prescaler are 0, asynchronously. Release is synchronous to the next clk edge.
- Priority per edge: clr > load > counting.
- clr = 1:
  - count, prescaler, overflow become 0; wrap and step become 0.
  - load and en are ignored that cycle.
- load = 1 (clr = 0):
  - count becomes min(load_val, MODULUS-1); prescaler becomes 0.
  - wrap and step become 0; overflow holds.
- Counting (clr = 0, load = 0, en = 1):
  - If prescaler != PRESCALE-1: prescaler increments and count holds.
  - Otherwise prescaler returns to 0 and count steps.
- Step rules:
  - Up: count == MODULUS-1 goes to 0, with wrap pulse and overflow set; otherwise count+1.
  - Down: count == 0 goes to MODULUS-1, with wrap pulse and overflow set; otherwise count-1.
- en = 0: count and prescaler hold; wrap and step return to 0.
- up_dn changing between steps affects only the next step; the prescaler is not reset.
- Latency: count updates on the same edge as the step decision. wrap and step are high in the cycle after that edge, coincident with the new count value.
- Arithmetic: compare against MODULUS-1 at WIDTH bits, with no reliance on natural 2**WIDTH rollover. MODULUS = 2**WIDTH must still wrap correctly.
- PRESCALE = 1: the prescaler logic reduces to a constant; a step occurs on every enabled cycle.

Optional Feature:
- Macro: PARAM_CNT_SATURATE_EN.
- Defined:
  - An up step at MODULUS-1 holds at MODULUS-1; a down step at 0 holds at 0.
  - wrap never pulses.
  - overflow is set on any attempted step beyond a bound and remains sticky.
  - step does not pulse on a held step.
- Undefined: modulo wrap behaviour as above.

Decomposition:
- Package cnt_pkg:
  - localparams CNT_DIR_UP = 1'b1 and CNT_DIR_DN = 1'b0.
  - function clamp_load(val, modulus).
  - function width check for elaboration-time assertion of MODULUS <= 2**WIDTH.
- Sub-module cnt_prescaler:
  - Parameter PRESCALE; inputs clk, rst, clr_sync (clr | load), en; output tick.
  - tick is combinational, high when en = 1 and the internal count is at PRESCALE-1.
- Top instantiates cnt_prescaler and holds the count, flag and pulse registers.

Test Plan:
- Reset with rst = 0 mid-count (count = 5) -> count, wrap, overflow, step = 0 immediately, without waiting for clk. After release, the first enabled edge gives count = 1.
- Up wrap (WIDTH = 3, MODULUS = 6, PRESCALE = 1), en = 1 for 7 cycles -> count 1,2,3,4,5,0,1. wrap is high exactly once, in the cycle count = 0. overflow = 1 thereafter.
- Down from 0, up_dn = 0 (MODULUS = 6) -> count 5,4,3. The wrap pulse aligns with count = 5.
- PRESCALE = 3, en = 1 for 9 cycles -> count 0,0,1,1,1,2,2,2,3. step pulses 3 times. Dropping en for 2 cycles mid-window holds both count and prescaler phase.
- Load clamp and priority: load = 1 with load_val = 7 (MODULUS = 6) -> count = 5. clr = 1 and load = 1 together -> count = 0 and overflow = 0.
- With PARAM_CNT_SATURATE_EN defined, 8 up steps from 0 (MODULUS = 6) -> count stops at 5, wrap stays 0, overflow = 1.
